i2s_seq: RTL and testbench

- EVB command-bus master that sequences the i2s serializer's control registers.
- On a start pulse it disables the serializer, polls until it drains, programs BCLK/LRCLK dividers, reads them back, then enables output.
- On a stop pulse it disables and waits for drain.
- Sits between the system control logic and the i2s block's evb_cmd_* slave port; owns that port exclusively.

---
 rtl/i2s_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2s_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_seq.sv
// i2s_seq: EVB command-bus master that disables, drains, programs, verifies and
// re-enables the i2s serializer in response to start/stop pulses.
`ifndef EVB_MASK_W
`define EVB_MASK_W 2'b11
`endif
`ifndef EVB_MASK_DUMMY
`define EVB_MASK_DUMMY 2'b00
`endif

module i2s_seq #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [31:0] cfg_bclk_div,
    input  logic [31:0] cfg_lrclk_div,
    output logic        running,
    output logic        seq_busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        i2s_cmd_request,
    output logic [3:0]  i2s_cmd_addr,
    output logic [1:0]  i2s_cmd_wr_mask,
    output logic [31:0] i2s_cmd_wr_data,
    input  logic        i2s_cmd_finish,
    input  logic [31:0] i2s_cmd_rd_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIS,
        S_POLL,
        S_WB,
        S_WL,
        S_RB,
        S_RL,
        S_EN,
        S_EDIS,
        S_RUN
    } state_t;

    localparam logic [3:0] A_STATUS = 4'd0;
    localparam logic [3:0] A_BCLK   = 4'd1;
    localparam logic [3:0] A_LRCLK  = 4'd2;

    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam int GC_W = $clog2(POLL_GAP + 2);
    localparam logic [PC_W-1:0] POLL_LAST  = PC_W'(POLL_MAX - 1);
    localparam logic [GC_W-1:0] GAP_RELOAD = (POLL_GAP > 0) ? GC_W'(POLL_GAP - 1) : '0;

    state_t            state;
    logic [31:0]       bclk_lat;
    logic [31:0]       lrclk_lat;
    logic [PC_W-1:0]   poll_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic              stopping;
    logic              stop_pend;

    logic              div_ok;
    logic              stop_req;
    logic              busy_bit;
    logic [3:0]        cmd_addr;
    logic              cmd_wr;
    logic [31:0]       cmd_data;

    // lrclk must cover at least 32 bclk half-periods; compare at 37 bits so it cannot wrap
    assign div_ok = (cfg_bclk_div != '0) && (cfg_lrclk_div != '0) &&
                    ({5'b0, cfg_lrclk_div} >= {cfg_bclk_div, 5'b0});

    // A stop only diverts a start sequence; stop paths and the error write-back ignore it
    assign stop_req = !stopping && (state != S_EDIS) && (stop_pend || cfg_stop);
    assign busy_bit = i2s_cmd_rd_data[0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cmd_addr = A_STATUS;
        cmd_wr   = 1'b0;
        cmd_data = '0;
        case (state)
            S_DIS, S_EDIS: cmd_wr = 1'b1;
            S_WB: begin
                cmd_addr = A_BCLK;
                cmd_wr   = 1'b1;
                cmd_data = bclk_lat;
            end
            S_WL: begin
                cmd_addr = A_LRCLK;
                cmd_wr   = 1'b1;
                cmd_data = lrclk_lat;
            end
            S_RB: cmd_addr = A_BCLK;
            S_RL: cmd_addr = A_LRCLK;
            S_EN: begin
                cmd_wr   = 1'b1;
                cmd_data = 32'h2;
            end
            default: ;
        endcase
    end

    // NOTE: all state and outputs below use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            running         <= 1'b0;
            seq_busy        <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            err_code        <= 2'd0;
            i2s_cmd_request <= 1'b0;
            i2s_cmd_addr    <= '0;
            i2s_cmd_wr_mask <= '0;
            i2s_cmd_wr_data <= '0;
            bclk_lat        <= '0;
            lrclk_lat       <= '0;
            poll_cnt        <= '0;
            gap_cnt         <= '0;
            stopping        <= 1'b0;
            stop_pend       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_RUN: begin
                    if (cfg_stop) begin
                        if (state == S_RUN) begin
                            state    <= S_DIS;
                            stopping <= 1'b1;
                            seq_busy <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (cfg_start) begin
                        bclk_lat  <= cfg_bclk_div;
                        lrclk_lat <= cfg_lrclk_div;
                        stop_pend <= 1'b0;
                        if (div_ok) begin
                            err      <= 1'b0;
                            err_code <= 2'd0;
                            state    <= S_DIS;
                            stopping <= 1'b0;
                            seq_busy <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                            done     <= 1'b1;
                        end
                    end
                end

                default: begin
                    if (stop_req && !stop_pend)
                        stop_pend <= 1'b1;

                    if (i2s_cmd_request) begin
                        if (i2s_cmd_finish) begin
                            i2s_cmd_request <= 1'b0;
                            case (state)
                                S_DIS: begin
                                    running  <= 1'b0;
                                    poll_cnt <= '0;
                                    state    <= S_POLL;
                                    if (stop_req) begin
                                        stopping  <= 1'b1;
                                        stop_pend <= 1'b0;
                                    end
                                end
                                S_EDIS: begin
                                    running  <= 1'b0;
                                    done     <= 1'b1;
                                    seq_busy <= 1'b0;
                                    state    <= S_IDLE;
                                end
                                S_POLL: begin
                                    if (stop_req) begin
                                        stopping  <= 1'b1;
                                        stop_pend <= 1'b0;
                                    end
                                    if (!busy_bit) begin
                                        if (stopping || stop_req) begin
                                            done     <= 1'b1;
                                            seq_busy <= 1'b0;
                                            state    <= S_IDLE;
                                        end else begin
                                            state <= S_WB;
                                        end
                                    end else if (poll_cnt == POLL_LAST) begin
                                        err      <= 1'b1;
                                        err_code <= 2'd2;
                                        done     <= 1'b1;
                                        seq_busy <= 1'b0;
                                        state    <= S_IDLE;
                                    end else begin
                                        poll_cnt <= poll_cnt + PC_W'(1);
                                        gap_cnt  <= GAP_RELOAD;
                                    end
                                end
                                S_RB, S_RL: begin
                                    if (i2s_cmd_rd_data != ((state == S_RB) ? bclk_lat : lrclk_lat)) begin
                                        err      <= 1'b1;
                                        err_code <= 2'd3;
                                        state    <= S_EDIS;
                                    end else if (stop_req) begin
                                        state     <= S_POLL;
                                        poll_cnt  <= '0;
                                        stopping  <= 1'b1;
                                        stop_pend <= 1'b0;
                                    end else begin
                                        state <= (state == S_RB) ? S_RL : S_EN;
                                    end
                                end
                                S_EN: begin
                                    running <= 1'b1;
                                    if (stop_req) begin
                                        state     <= S_DIS;
                                        stopping  <= 1'b1;
                                        stop_pend <= 1'b0;
                                    end else begin
                                        done     <= 1'b1;
                                        seq_busy <= 1'b0;
                                        state    <= S_RUN;
                                    end
                                end
                                default: begin
                                    // WB and WL: advance, or fall back to draining on a pending stop
                                    if (stop_req) begin
                                        state     <= S_POLL;
                                        poll_cnt  <= '0;
                                        stopping  <= 1'b1;
                                        stop_pend <= 1'b0;
                                    end else begin
                                        state <= (state == S_WB) ? S_WL : S_RB;
                                    end
                                end
                            endcase
                        end
                    end else if (stop_req) begin
                        stopping  <= 1'b1;
                        stop_pend <= 1'b0;
                        if (state != S_DIS && state != S_POLL) begin
                            state    <= S_POLL;
                            poll_cnt <= '0;
                        end
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GC_W'(1);
                    end else if (!i2s_cmd_finish) begin
                        i2s_cmd_request <= 1'b1;
                        i2s_cmd_addr    <= cmd_addr;
                        i2s_cmd_wr_mask <= cmd_wr ? `EVB_MASK_W : `EVB_MASK_DUMMY;
                        i2s_cmd_wr_data <= cmd_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_seq.sv
// tb_i2s_seq: directed bench for i2s_seq with a small EVB slave model that logs
// every command and can hold busy or corrupt the BCLK readback.
`ifndef EVB_MASK_W
`define EVB_MASK_W 2'b11
`endif
`ifndef EVB_MASK_DUMMY
`define EVB_MASK_DUMMY 2'b00
`endif

module tb_i2s_seq;

    localparam int POLL_MAX = 4;
    localparam int POLL_GAP = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_stop;
    logic [31:0] cfg_bclk_div, cfg_lrclk_div;
    logic        running, seq_busy, done, err;
    logic [1:0]  err_code;
    logic        req;
    logic [3:0]  addr;
    logic [1:0]  mask;
    logic [31:0] wdata;
    logic        finish;
    logic [31:0] rd_data;

    i2s_seq #(.POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_stop        (cfg_stop),
        .cfg_bclk_div    (cfg_bclk_div),
        .cfg_lrclk_div   (cfg_lrclk_div),
        .running         (running),
        .seq_busy        (seq_busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .i2s_cmd_request (req),
        .i2s_cmd_addr    (addr),
        .i2s_cmd_wr_mask (mask),
        .i2s_cmd_wr_data (wdata),
        .i2s_cmd_finish  (finish),
        .i2s_cmd_rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wr_op(input logic [3:0] a, input logic [31:0] d);
        return {27'b0, 1'b1, a, d};
    endfunction

    function automatic logic [63:0] rd_op(input logic [3:0] a);
        return {27'b0, 1'b0, a, 32'b0};
    endfunction

    // Slave model: finish two cycles after request is seen, one-cycle pulse
    int          busy_left = 0;
    bit          bclk_bad  = 1'b0;
    logic [31:0] bclk_reg, lrclk_reg;
    int          lat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            finish    <= 1'b0;
            rd_data   <= '0;
            bclk_reg  <= '0;
            lrclk_reg <= '0;
            lat = 0;
        end else begin
            finish <= 1'b0;
            if (req && !finish) begin
                if (lat == 1) begin
                    lat = 0;
                    finish <= 1'b1;
                    if (mask == `EVB_MASK_W) begin
                        rd_data <= '0;
                        if (addr == 4'd1) bclk_reg  <= wdata;
                        if (addr == 4'd2) lrclk_reg <= wdata;
                    end else begin
                        case (addr)
                            4'd0: begin
                                rd_data <= (busy_left > 0) ? 32'h1 : 32'h0;
                                if (busy_left > 0) busy_left--;
                            end
                            4'd1:    rd_data <= bclk_bad ? 32'd5 : bclk_reg;
                            4'd2:    rd_data <= lrclk_reg;
                            default: rd_data <= '0;
                        endcase
                    end
                end else begin
                    lat++;
                end
            end
        end
    end

    // Bus monitor, sampled on the falling edge
    logic [63:0] log_q[$];
    int          idle_q[$];
    logic [63:0] exp_q[$];
    int          cyc = 0, last_high = -100, done_cnt = 0, mask_err = 0, proto_err = 0;
    logic        prev_req = 1'b0, prev_fin_req = 1'b0;
    logic [37:0] prev_cmd = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_req     = 1'b0;
            prev_fin_req = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (req && !prev_req) begin
                if (mask != `EVB_MASK_W && mask != `EVB_MASK_DUMMY) mask_err++;
                if (finish) proto_err++;
                log_q.push_back((mask == `EVB_MASK_W) ? wr_op(addr, wdata) : rd_op(addr));
                idle_q.push_back(cyc - last_high - 1);
            end
            if (req && prev_req && {addr, mask, wdata} != prev_cmd) proto_err++;
            if (req && prev_fin_req) proto_err++;
            if (req) last_high = cyc;
            prev_req     = req;
            prev_fin_req = req && finish;
            prev_cmd     = {addr, mask, wdata};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic p, input logic [31:0] b, input logic [31:0] l);
        @(posedge clk);
        #1;
        cfg_start     = s;
        cfg_stop      = p;
        cfg_bclk_div  = b;
        cfg_lrclk_div = l;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) @(posedge clk);
        tick(4);
        check({tag, " done pulses"}, done_cnt - base, 1);
    endtask

    task automatic check_log(input string tag);
        check({tag, " op count"}, log_q.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s op%0d", tag, i), (i < log_q.size()) ? log_q[i] : 64'hDEAD, exp_q[i]);
    endtask

    task automatic clear_log();
        log_q.delete();
        idle_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int found;
        int n_bad;

        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        cfg_bclk_div = '0;
        cfg_lrclk_div = '0;
        tick(3);
        check("reset outputs", {running, seq_busy, done, err, err_code, req}, '0);
        rst = 1'b0;
        tick(2);
        check("post-reset idle", {running, seq_busy, req}, '0);

        // Full start; busy clears on the second status read
        clear_log();
        busy_left = 1;
        pulse(1'b1, 1'b0, 32'd4, 32'd128);
        check("start busy", seq_busy, 1'b1);
        wait_done("start", 400);
        exp_q = {wr_op(0, 0), rd_op(0), rd_op(0), wr_op(1, 4), wr_op(2, 128),
                 rd_op(1), rd_op(2), wr_op(0, 2)};
        check_log("start");
        check("start running/busy/err", {running, seq_busy, err}, 3'b100);

        // Bad divider ratio: rejected from RUN without traffic
        clear_log();
        pulse(1'b1, 1'b0, 32'd4, 32'd100);
        wait_done("reject", 20);
        check("reject err", {err, err_code}, 3'b101);
        check("reject traffic", log_q.size(), 0);
        check("reject keeps run", {running, seq_busy}, 2'b10);

        // Stop from RUN, drain takes three reads
        clear_log();
        busy_left = 2;
        pulse(1'b0, 1'b1, 32'd0, 32'd0);
        wait_done("stop", 400);
        exp_q = {wr_op(0, 0), rd_op(0), rd_op(0), rd_op(0)};
        check_log("stop");
        check("stop running/busy", {running, seq_busy}, 2'b00);

        // Stop while idle: pulse only
        clear_log();
        pulse(1'b0, 1'b1, 32'd0, 32'd0);
        wait_done("idle stop", 20);
        check("idle stop traffic", log_q.size(), 0);

        // Drain never completes
        clear_log();
        busy_left = 1000000;
        pulse(1'b1, 1'b0, 32'd4, 32'd128);
        wait_done("timeout", 600);
        exp_q = {wr_op(0, 0), rd_op(0), rd_op(0), rd_op(0), rd_op(0)};
        check_log("timeout");
        check("timeout err", {err, err_code}, 3'b110);
        for (int i = 2; i < 5; i++)
            check($sformatf("poll gap %0d", i), (i < idle_q.size()) && (idle_q[i] >= POLL_GAP), 1'b1);
        check("timeout running/busy", {running, seq_busy}, 2'b00);

        // Corrupted BCLK readback
        clear_log();
        busy_left = 0;
        bclk_bad = 1'b1;
        pulse(1'b1, 1'b0, 32'd4, 32'd128);
        wait_done("readback", 400);
        exp_q = {wr_op(0, 0), rd_op(0), wr_op(1, 4), wr_op(2, 128), rd_op(1), wr_op(0, 0)};
        check_log("readback");
        check("readback err", {err, err_code}, 3'b111);
        check("readback running", running, 1'b0);

        // Back to RUN with a clean bus
        bclk_bad = 1'b0;
        pulse(1'b1, 1'b0, 32'd2, 32'd64);
        wait_done("restart", 400);
        check("restart state", {running, seq_busy, err}, 3'b100);

        // Start and stop together in RUN: stop only
        clear_log();
        pulse(1'b1, 1'b1, 32'd4, 32'd128);
        wait_done("start+stop", 400);
        exp_q = {wr_op(0, 0), rd_op(0)};
        check_log("start+stop");
        check("start+stop running", running, 1'b0);

        // Stop arriving while the BCLK write is outstanding
        clear_log();
        pulse(1'b1, 1'b0, 32'd4, 32'd128);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (req && addr == 4'd1 && mask == `EVB_MASK_W) found = 1;
            else tick(1);
        end
        check("wb seen", found, 1);
        pulse(1'b0, 1'b1, 32'd0, 32'd0);
        wait_done("stop in wb", 400);
        check("wb op0", (log_q.size() > 0) ? log_q[0] : 64'hDEAD, wr_op(0, 0));
        check("wb op2", (log_q.size() > 2) ? log_q[2] : 64'hDEAD, wr_op(1, 4));
        check("wb last is poll", (log_q.size() > 0) ? log_q[log_q.size() - 1] : 64'hDEAD, rd_op(0));
        n_bad = 0;
        foreach (log_q[i])
            if (log_q[i] == wr_op(0, 2) || log_q[i][35:32] == 4'd2) n_bad++;
        check("wb no en/lrclk", n_bad, 0);
        check("wb running/busy/err", {running, seq_busy, err}, 3'b000);

        // Reset while a request is outstanding
        pulse(1'b1, 1'b0, 32'd4, 32'd128);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (req) found = 1;
            else tick(1);
        end
        check("req before rst", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst drops req", {req, seq_busy, running}, 3'b000);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("after rst idle", {req, seq_busy, done}, 3'b000);

        check("mask encoding", mask_err, 0);
        check("handshake rules", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
